// File: rtl/score_digit_ctrl_if.sv
// Score display bus: score update strobe, raster position, font ROM handshake,
// pixel result and conversion status. Clock and reset stay outside.
interface score_digit_ctrl_if #(
  parameter int SCORE_W = 20
);
  logic [SCORE_W-1:0] score;
  logic               score_valid;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic [7:0]         font_data;
  logic [10:0]        font_addr;
  logic               pixel_on;
  logic               busy;

  modport slave (
    input  score, score_valid, DrawX, DrawY, font_data,
    output font_addr, pixel_on, busy
  );

  modport master (
    output score, score_valid, DrawX, DrawY, font_data,
    input  font_addr, pixel_on, busy
  );
endinterface

// File: rtl/score_digit_ctrl.sv
// Score digit controller: binary score -> BCD (serial double-dabble), latched
// display digits, and a one-stage font ROM addressing pipeline.
// Optional macro SCORE_LZB_EN enables leading-zero blanking.
module score_digit_ctrl #(
  parameter int         SCORE_W    = 20,
  parameter int         NUM_DIGITS = 6,
  parameter logic [9:0] ORIGIN_X   = 10'd8,
  parameter logic [9:0] ORIGIN_Y   = 10'd8
) (
  input  logic            Clk,
  input  logic            Reset_n,
  score_digit_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(SCORE_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [10:0] X_END   = 11'(ORIGIN_X) + 11'(8 * NUM_DIGITS);
  localparam logic [10:0] Y_END   = 11'(ORIGIN_Y) + 11'd16;

  // Clamp to the largest value the digit row can show.
  function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] s);
    if (64'(s) > MAX_VAL) return MAX_VAL[SCORE_W-1:0];
    return s;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e                          state_q;
  logic [SCORE_W-1:0]              sr_q;
  logic [NUM_DIGITS-1:0][3:0]      bcd_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            pend_q;
  logic [SCORE_W-1:0]              pend_score_q;
  logic [NUM_DIGITS-1:0][3:0]      disp_q;   // [NUM_DIGITS-1] is the MSD
  logic                            busy_q;

  logic [NUM_DIGITS-1:0][3:0]      bcd_adj;
  logic [NUM_DIGITS-1:0][3:0]      bcd_d;
  logic [SCORE_W-1:0]              sr_d;

  // One double-dabble step: add-3 correction, then shift {bcd, sr} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
    {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
  end

  // Conversion FSM. A strobe landing in COMMIT is taken directly as the
  // reload value so it is neither lost nor left stranded in IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      pend_score_q <= '0;
      disp_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.score_valid) begin
            sr_q    <= sat(bus.score);
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.score_valid) begin
            pend_score_q <= bus.score;
            pend_q       <= 1'b1;
          end
          if (cnt_q == CNT_W'(SCORE_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          disp_q <= bcd_q;
          if (bus.score_valid || pend_q) begin
            sr_q    <= sat(bus.score_valid ? bus.score : pend_score_q);
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Raster decode: box test, digit slot, glyph column and row.
  logic        in_box;
  logic [9:0]  dx;
  logic [6:0]  slot;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [3:0]  dig;
  logic        blank;

  assign dx     = bus.DrawX - ORIGIN_X;
  assign slot   = dx[9:3];
  assign col    = dx[2:0];
  assign row    = bus.DrawY[3:0] - ORIGIN_Y[3:0];
  assign in_box = (bus.DrawX >= ORIGIN_X) && ({1'b0, bus.DrawX} < X_END) &&
                  (bus.DrawY >= ORIGIN_Y) && ({1'b0, bus.DrawY} < Y_END);

  // Select the digit shown in the current slot (slot 0 = most significant).
  always_comb begin
    dig = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (slot == 7'(i)) dig = disp_q[NUM_DIGITS-1-i];
  end

`ifdef SCORE_LZB_EN
  // Blank a slot when it and every more-significant digit are zero; the
  // last slot always draws so zero still shows one digit.
  always_comb begin
    logic lz;
    lz    = 1'b1;
    blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz = lz & (disp_q[NUM_DIGITS-1-i] == 4'd0);
      if (slot == 7'(i)) blank = lz && (i != NUM_DIGITS - 1);
    end
  end
`else
  assign blank = 1'b0;
`endif

  logic [10:0] font_addr_q;
  logic        in_box_q;
  logic        blank_q;
  logic [2:0]  col_q;

  // Display stage: ROM address updates only inside the box; qualifiers always.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      font_addr_q <= '0;
      in_box_q    <= 1'b0;
      blank_q     <= 1'b0;
      col_q       <= '0;
    end else begin
      if (in_box) font_addr_q <= {3'b000, dig, row};
      in_box_q <= in_box;
      blank_q  <= blank;
      col_q    <= col;
    end
  end

  assign bus.font_addr = font_addr_q;
  assign bus.pixel_on  = in_box_q & ~blank_q & bus.font_data[3'd7 - col_q];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Bench for score_digit_ctrl: fixed vector table, hand-built multi-cycle
// sequences, and random score/pixel traffic against an arithmetic model.
module tb_score_digit_ctrl;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  score_digit_ctrl_if #(.SCORE_W(20)) bus ();

  score_digit_ctrl #(
    .SCORE_W(20), .NUM_DIGITS(6), .ORIGIN_X(10'd8), .ORIGIN_Y(10'd8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
  );

  always #5 Clk = ~Clk;

  // ROM model: two rows from a real glyph set, the rest address-derived.
  function automatic logic [7:0] rom_f(input logic [10:0] a);
    case (a)
      11'd2:   return 8'h7C;
      11'd18:  return 8'h18;
      default: return a[7:0];
    endcase
  endfunction

  assign bus.font_data = rom_f(bus.font_addr);

  // Reference model: decimal digits by division, blanking by magnitude.
  function automatic int pw10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int sat_ref(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic int digit_ref(input int val, input int k);
    return (val / pw10(5 - k)) % 10;
  endfunction

  function automatic bit blank_ref(input int val, input int k);
`ifdef SCORE_LZB_EN
    return (k != 5) && (val < pw10(5 - k));
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic park();
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd0;
  endtask

  // Strobe a value for one edge; returns 1 time unit after that edge.
  task automatic strobe(input int v);
    bus.score       = 20'(v);
    bus.score_valid = 1'b1;
    tick();
    bus.score_valid = 1'b0;
  endtask

  // Count cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  // Present a pixel, then compare against the model for value val.
  int last_addr = 0;
  task automatic pix_chk(input string name, input int val, input int x, input int y);
    int k, col, row, ea, ep;
    bit inb;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    tick();
    inb = (x >= 8) && (x < 56) && (y >= 8) && (y < 24);
    if (inb) begin
      k   = (x - 8) / 8;
      col = (x - 8) % 8;
      row = y - 8;
      ea  = digit_ref(val, k) * 16 + row;
      ep  = blank_ref(val, k) ? 0 : int'(rom_f(11'(ea)) >> (7 - col)) & 1;
      last_addr = ea;
    end else begin
      ea = last_addr;
      ep = 0;
    end
    chk({name, "_addr"}, int'(bus.font_addr), ea);
    chk({name, "_pix"},  int'(bus.pixel_on),  ep);
  endtask

  typedef struct {
    int score;
    int x;
    int y;
    int exp_addr;
    int exp_pix;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n, cur, nstrb;
    bus.score       = '0;
    bus.score_valid = 1'b0;
    park();

    vecs[0] = '{1234,    27, 10, 18,  1};
    vecs[1] = '{1000000, 11, 10, 146, 1};
    vecs[2] = '{999999,  48, 23, 159, 1};
    vecs[3] = '{5,       49,  8, 80,  1};
    vecs[4] = '{42,      42,  9, 65,  0};
    vecs[5] = '{0,       50, 10, 2,   1};
`ifdef SCORE_LZB_EN
    vecs[6] = '{0,       10, 10, 2,   0};
`else
    vecs[6] = '{0,       10, 10, 2,   1};
`endif
    vecs[7] = '{123456,  23, 13, 37,  1};
    vecs[8] = '{50000,   21, 15, 87,  1};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_addr", int'(bus.font_addr), 0);
    chk("rst_pix",  int'(bus.pixel_on), 0);
    #4 Reset_n = 1'b1;
    tick();

    // Reset mid-conversion with a pending value queued
    bus.DrawX = 10'd50;
    bus.DrawY = 10'd10;
    strobe(1234);
    repeat (3) tick();
    strobe(555);
    tick();
    Reset_n = 1'b0;
    #2;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_addr", int'(bus.font_addr), 0);
    chk("midrst_pix",  int'(bus.pixel_on), 0);
    #4 Reset_n = 1'b1;
    tick();
    chk("postrst_addr", int'(bus.font_addr), 2);
    chk("postrst_pix",  int'(bus.pixel_on), 1);
    repeat (30) tick();
    chk("postrst_busy", int'(bus.busy), 0);
    chk("postrst_hold", int'(bus.font_addr), 2);
    park();

    // Vector table
    for (int i = 0; i < 9; i++) begin
      strobe(vecs[i].score);
      wait_idle(n);
      bus.DrawX = 10'(vecs[i].x);
      bus.DrawY = 10'(vecs[i].y);
      tick();
      chk($sformatf("vec%0d_addr", i), int'(bus.font_addr), vecs[i].exp_addr);
      chk($sformatf("vec%0d_pix", i),  int'(bus.pixel_on),  vecs[i].exp_pix);
      park();
    end

    // Box boundaries: address holds, pixel off
    pix_chk("bnd_in", 50000, 49, 8);
    pix_chk("bnd_right", 50000, 56, 8);
    pix_chk("bnd_below", 50000, 49, 24);
    pix_chk("bnd_left", 50000, 7, 8);
    pix_chk("bnd_above", 50000, 49, 7);

    // Single conversion latency
    strobe(1234);
    wait_idle(n);
    chk("lat_1234", n, 21);

    // Back-to-back: 77 overwritten by 99 while busy
    bus.DrawX = 10'd49;
    bus.DrawY = 10'd8;
    strobe(5);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 4) begin bus.score = 20'd77; bus.score_valid = 1'b1; end
      else if (n == 7) begin bus.score = 20'd99; bus.score_valid = 1'b1; end
      else bus.score_valid = 1'b0;
      if (n == 23) chk("b2b_first", int'(bus.font_addr), 80);
      tick();
    end
    bus.score_valid = 1'b0;
    chk("b2b_busy", n, 42);
    tick();
    chk("b2b_final_addr", int'(bus.font_addr), 144);
    chk("b2b_final_pix",  int'(bus.pixel_on), 0);

    // Strobe lands in the COMMIT cycle
    park();
    strobe(7);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      if (n == 21) begin bus.score = 20'd42; bus.score_valid = 1'b1; end
      else bus.score_valid = 1'b0;
      tick();
    end
    bus.score_valid = 1'b0;
    chk("commit_busy", n, 42);
    pix_chk("commit_d4", 42, 41, 8);
    pix_chk("commit_d5", 42, 49, 8);

    // Random traffic: latest strobe wins
    for (int it = 0; it < 40; it++) begin
      park();
      case ($urandom_range(0, 3))
        0: cur = int'($urandom_range(0, 1048575));
        1: cur = int'($urandom_range(0, 999));
        2: cur = int'($urandom_range(999990, 1048575));
        default: cur = int'($urandom_range(0, 99999));
      endcase
      strobe(cur);
      nstrb = int'($urandom_range(0, 2));
      for (int s = 0; s < nstrb; s++) begin
        repeat ($urandom_range(0, 12)) tick();
        cur = int'($urandom_range(0, 1048575));
        strobe(cur);
      end
      wait_idle(n);
      cur = sat_ref(cur);
      pix_chk("rnd_in", cur, int'($urandom_range(8, 55)), int'($urandom_range(8, 23)));
      for (int p = 0; p < 4; p++)
        pix_chk("rnd_px", cur, int'($urandom_range(0, 63)), int'($urandom_range(4, 27)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
